// File: rtl/vid_pattern_gen_if.sv
// Video timing and multi-pixel RGB/YUV bus between the pattern source and the conversion stage.
// Pixel p of a beat sits at bits [p*C_BPP +: C_BPP].
interface vid_pattern_gen_if #(
   parameter int unsigned C_BPP      = 8,
   parameter int unsigned C_PORT_NUM = 4
);
   logic                          M_VS;
   logic                          M_HS;
   logic                          M_DE;
   logic [C_BPP*C_PORT_NUM-1:0]   M_R_Y;
   logic [C_BPP*C_PORT_NUM-1:0]   M_G_U;
   logic [C_BPP*C_PORT_NUM-1:0]   M_B_V;

   modport master (output M_VS, M_HS, M_DE, M_R_Y, M_G_U, M_B_V);
   modport slave  (input  M_VS, M_HS, M_DE, M_R_Y, M_G_U, M_B_V);
endinterface

// File: rtl/vid_pattern_gen.sv
// Frame-aligned video timing generator with bars/ramp/solid/checker test patterns,
// C_PORT_NUM pixels per clock, outputs registered one clock after the counters.
module vid_pattern_gen #(
   parameter int unsigned      C_BPP       = 8,
   parameter int unsigned      C_PORT_NUM  = 4,
   parameter int unsigned      C_H_SYNC    = 2,
   parameter int unsigned      C_H_BP      = 4,
   parameter int unsigned      C_H_ACTIVE  = 16,
   parameter int unsigned      C_H_FP      = 3,
   parameter int unsigned      C_V_SYNC    = 1,
   parameter int unsigned      C_V_BP      = 2,
   parameter int unsigned      C_V_ACTIVE  = 4,
   parameter int unsigned      C_V_FP      = 1,
   parameter int unsigned      C_BAR_SHIFT = 3,
   parameter int unsigned      C_CHK_SHIFT = 2,
   parameter logic [C_BPP-1:0] C_SOLID     = 8'h80
) (
   input  logic                     VID_CLK,
   input  logic                     VID_RSTN,
   input  logic                     EN,
   input  logic [1:0]               PATTERN_SEL,
   vid_pattern_gen_if.master        m_vid,
   output logic [15:0]              FRAME_CNT,
   output logic                     BUSY
);

   localparam int unsigned HT  = C_H_SYNC + C_H_BP + C_H_ACTIVE + C_H_FP;
   localparam int unsigned VT  = C_V_SYNC + C_V_BP + C_V_ACTIVE + C_V_FP;
   localparam int unsigned HW  = (HT > 1) ? $clog2(HT) : 1;
   localparam int unsigned VW  = (VT > 1) ? $clog2(VT) : 1;
   localparam int unsigned DW  = C_BPP * C_PORT_NUM;
   // x is only needed modulo 2^XW: ramp, bar index and checker bit all live below XW.
   localparam int unsigned XW0 = (C_BAR_SHIFT + 3 > C_BPP) ? C_BAR_SHIFT + 3 : C_BPP;
   localparam int unsigned XW  = (C_CHK_SHIFT + 1 > XW0) ? C_CHK_SHIFT + 1 : XW0;
   localparam int unsigned YW  = C_CHK_SHIFT + 1;

   localparam logic [HW-1:0] H_SYNC_END = HW'(C_H_SYNC);
   localparam logic [HW-1:0] H_ACT_BEG  = HW'(C_H_SYNC + C_H_BP);
   localparam logic [HW-1:0] H_ACT_END  = HW'(C_H_SYNC + C_H_BP + C_H_ACTIVE);
   localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(C_V_SYNC);
   localparam logic [VW-1:0] V_ACT_BEG  = VW'(C_V_SYNC + C_V_BP);
   localparam logic [VW-1:0] V_ACT_END  = VW'(C_V_SYNC + C_V_BP + C_V_ACTIVE);
   localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
   localparam logic [YW-1:0] Y_MASK     = YW'(1) << C_CHK_SHIFT;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          r_state, w_state_nxt;
   logic [HW-1:0]   r_h, w_h_nxt;
   logic [VW-1:0]   r_v, w_v_nxt;
   logic [1:0]      r_pat, w_pat_nxt;
   logic [15:0]     r_fcnt, w_fcnt_nxt;

   logic            w_eol, w_eof;
   logic            w_hs, w_vs, w_de, w_ychk;
   logic [XW-1:0]   w_xbase;
   logic [XW-1:0]   w_x [C_PORT_NUM];
   logic [DW-1:0]   w_r_y, w_g_u, w_b_v;

   logic            r_vs, r_hs, r_de;
   logic [DW-1:0]   r_r_y, r_g_u, r_b_v;

   assign w_eol = (r_h == H_LAST);
   assign w_eof = w_eol && (r_v == V_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      w_pat_nxt   = r_pat;
      w_fcnt_nxt  = r_fcnt;
      unique case (r_state)
         StIdle: begin
            if (EN) begin
               w_state_nxt = StRun;
               w_h_nxt     = '0;
               w_v_nxt     = '0;
               w_pat_nxt   = PATTERN_SEL;
            end
         end
         StRun: begin
            if (w_eol) begin
               w_h_nxt = '0;
               if (w_eof) begin
                  // Frame boundary: the only point where EN and PATTERN_SEL are honoured.
                  w_v_nxt    = '0;
                  w_fcnt_nxt = r_fcnt + 16'd1;
                  w_pat_nxt  = PATTERN_SEL;
                  if (!EN) w_state_nxt = StIdle;
               end else begin
                  w_v_nxt = r_v + VW'(1);
               end
            end else begin
               w_h_nxt = r_h + HW'(1);
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
      if (!VID_RSTN) begin
         r_state <= StIdle;
         r_h     <= '0;
         r_v     <= '0;
         r_pat   <= '0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         r_pat   <= w_pat_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_hs    = (r_h < H_SYNC_END);
      w_vs    = (r_v < V_SYNC_END);
      w_de    = (r_h >= H_ACT_BEG) && (r_h < H_ACT_END) &&
                (r_v >= V_ACT_BEG) && (r_v < V_ACT_END);
      w_xbase = XW'(r_h - H_ACT_BEG) * XW'(C_PORT_NUM);
      w_ychk  = |(YW'(r_v - V_ACT_BEG) & Y_MASK);
      for (int p = 0; p < int'(C_PORT_NUM); p++) begin
         w_x[p] = w_xbase + XW'(p);
      end
   end

   always_comb begin
      w_r_y = '0;
      w_g_u = '0;
      w_b_v = '0;
      if (w_de) begin
         for (int p = 0; p < int'(C_PORT_NUM); p++) begin
            unique case (r_pat)
               2'd0: begin
                  // Bar index bits: [1]=0 -> R on, [2]=0 -> G on, [0]=0 -> B on.
                  w_r_y[p*C_BPP +: C_BPP] = {C_BPP{~w_x[p][C_BAR_SHIFT+1]}};
                  w_g_u[p*C_BPP +: C_BPP] = {C_BPP{~w_x[p][C_BAR_SHIFT+2]}};
                  w_b_v[p*C_BPP +: C_BPP] = {C_BPP{~w_x[p][C_BAR_SHIFT]}};
               end
               2'd1: begin
                  w_r_y[p*C_BPP +: C_BPP] = w_x[p][C_BPP-1:0];
                  w_g_u[p*C_BPP +: C_BPP] = w_x[p][C_BPP-1:0];
                  w_b_v[p*C_BPP +: C_BPP] = w_x[p][C_BPP-1:0];
               end
               2'd2: begin
                  w_r_y[p*C_BPP +: C_BPP] = C_SOLID;
                  w_g_u[p*C_BPP +: C_BPP] = C_SOLID;
                  w_b_v[p*C_BPP +: C_BPP] = C_SOLID;
               end
               2'd3: begin
                  w_r_y[p*C_BPP +: C_BPP] = {C_BPP{w_x[p][C_CHK_SHIFT] ^ w_ychk}};
                  w_g_u[p*C_BPP +: C_BPP] = {C_BPP{w_x[p][C_CHK_SHIFT] ^ w_ychk}};
                  w_b_v[p*C_BPP +: C_BPP] = {C_BPP{w_x[p][C_CHK_SHIFT] ^ w_ychk}};
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
      if (!VID_RSTN) begin
         r_vs  <= 1'b0;
         r_hs  <= 1'b0;
         r_de  <= 1'b0;
         r_r_y <= '0;
         r_g_u <= '0;
         r_b_v <= '0;
      end else if (r_state == StRun) begin
         r_vs  <= w_vs;
         r_hs  <= w_hs;
         r_de  <= w_de;
         r_r_y <= w_r_y;
         r_g_u <= w_g_u;
         r_b_v <= w_b_v;
      end else begin
         r_vs  <= 1'b0;
         r_hs  <= 1'b0;
         r_de  <= 1'b0;
         r_r_y <= '0;
         r_g_u <= '0;
         r_b_v <= '0;
      end
   end

   assign m_vid.M_VS  = r_vs;
   assign m_vid.M_HS  = r_hs;
   assign m_vid.M_DE  = r_de;
   assign m_vid.M_R_Y = r_r_y;
   assign m_vid.M_G_U = r_g_u;
   assign m_vid.M_B_V = r_b_v;
   assign FRAME_CNT   = r_fcnt;
   assign BUSY        = (r_state == StRun);

endmodule
